// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
//
// Compares two WIDTH-bit operands MSB-first, DIGIT bits per clock. Stops at the
// first differing digit. Reports the result on registered flags and pulses done
// for one cycle.
//
// Parameters:
//   WIDTH  operand width in bits (a multiple of DIGIT)
//   DIGIT  bits compared per clock (1 <= DIGIT <= WIDTH)
//
// Ports:
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   start        request a comparison (accepted only when idle)
//   a, b         operands, sampled on the accepted start edge
//   signed_mode  (SIGNED_COMPARE_EN only) two's-complement ordering when 1
//   busy         high while digits are being compared
//   done         one-cycle pulse when the result becomes valid
//   f1 / f2 / f3 a > b / a == b / a < b, held until the next accepted start
//
// Optional feature: define SIGNED_COMPARE_EN to add the signed_mode input.
// Without it the comparison is always unsigned.

module serial_magnitude_comparator #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SIGNED_COMPARE_EN
    input  logic             signed_mode,
`endif
    output logic             busy,
    output logic             done,
    output logic             f1,
    output logic             f2,
    output logic             f3
);

    localparam int unsigned N    = WIDTH / DIGIT;
    localparam int unsigned CW   = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned LAST = N - 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] load_a;
    logic [WIDTH-1:0] load_b;
    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;

    // Inverting both sign bits maps two's-complement order onto unsigned order.
    always_comb begin
        load_a = a;
        load_b = b;
`ifdef SIGNED_COMPARE_EN
        if (signed_mode) begin
            load_a[WIDTH-1] = ~a[WIDTH-1];
            load_b[WIDTH-1] = ~b[WIDTH-1];
        end
`endif
    end

    assign dig_a = sh_a[WIDTH-1 -: DIGIT];
    assign dig_b = sh_b[WIDTH-1 -: DIGIT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= StIdle;
            sh_a  <= '0;
            sh_b  <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            f1    <= 1'b0;
            f2    <= 1'b0;
            f3    <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        sh_a  <= load_a;
                        sh_b  <= load_b;
                        cnt   <= '0;
                        f1    <= 1'b0;
                        f2    <= 1'b0;
                        f3    <= 1'b0;
                        busy  <= 1'b1;
                        state <= StRun;
                    end
                end
                StRun: begin
                    if (dig_a > dig_b) begin
                        f1    <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end else if (dig_a < dig_b) begin
                        f3    <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end else if (cnt == CW'(LAST)) begin
                        f2    <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= StDone;
                    end else begin
                        sh_a <= sh_a << DIGIT;
                        sh_b <= sh_b << DIGIT;
                        cnt  <= cnt + CW'(1);
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator: an 8-bit/2-bit instance for
// the main cases and a 2-bit/1-bit instance swept against a 2-bit reference.

module tb_serial_magnitude_comparator;

    logic       clk;
    logic       rst_n;

    logic       start8;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       busy8, done8, f1_8, f2_8, f3_8;

    logic       start2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       busy2, done2, f1_2, f2_2, f3_2;

`ifdef SIGNED_COMPARE_EN
    logic       sm;
`endif

    int n_checks = 0;
    int n_errors = 0;

    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(2)) dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start8),
        .a          (a8),
        .b          (b8),
`ifdef SIGNED_COMPARE_EN
        .signed_mode(sm),
`endif
        .busy       (busy8),
        .done       (done8),
        .f1         (f1_8),
        .f2         (f2_8),
        .f3         (f3_8)
    );

    serial_magnitude_comparator #(.WIDTH(2), .DIGIT(1)) dut2 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start2),
        .a          (a2),
        .b          (b2),
`ifdef SIGNED_COMPARE_EN
        .signed_mode(sm),
`endif
        .busy       (busy2),
        .done       (done2),
        .f1         (f1_2),
        .f2         (f2_2),
        .f3         (f3_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One comparison on the 8-bit instance; operands are scrambled after the
    // start edge to show they are not re-sampled.
    task automatic run8(input string tag, input logic [7:0] ta, input logic [7:0] tb_v,
                        input logic [2:0] ef, input int el);
        int lat;
        @(negedge clk);
        a8 = ta;
        b8 = tb_v;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        a8 = ~ta;
        b8 = ~tb_v;
        check({tag, "_busy"}, 32'(busy8), 32'd1);
        check({tag, "_clr"}, 32'({f1_8, f2_8, f3_8}), 32'd0);
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done8 && lat < 20);
        check({tag, "_lat"}, 32'(lat), 32'(el));
        check({tag, "_flags"}, 32'({f1_8, f2_8, f3_8}), 32'(ef));
        check({tag, "_busy_off"}, 32'(busy8), 32'd0);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 32'(done8), 32'd0);
    endtask

    task automatic run2(input logic [1:0] ta, input logic [1:0] tb_v);
        int lat;
        int el;
        logic [2:0] ef;
        // Reference 2-bit combinational comparator.
        ef = {ta > tb_v, ta == tb_v, ta < tb_v};
        el = (ta[1] != tb_v[1]) ? 1 : 2;
        @(negedge clk);
        a2 = ta;
        b2 = tb_v;
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2 = 1'b0;
        lat = 0;
        do begin
            @(posedge clk);
            #1;
            lat++;
        end while (!done2 && lat < 10);
        check($sformatf("sweep_%0d_%0d_lat", ta, tb_v), 32'(lat), 32'(el));
        check($sformatf("sweep_%0d_%0d_flags", ta, tb_v), 32'({f1_2, f2_2, f3_2}), 32'(ef));
        @(posedge clk);
        #1;
    endtask

    initial begin
        int lat;
        int pulses;

        rst_n  = 1'b0;
        start8 = 1'b0;
        start2 = 1'b0;
        a8 = '0;
        b8 = '0;
        a2 = '0;
        b2 = '0;
`ifdef SIGNED_COMPARE_EN
        sm = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        check("reset8", 32'({busy8, done8, f1_8, f2_8, f3_8}), 32'd0);
        check("reset2", 32'({busy2, done2, f1_2, f2_2, f3_2}), 32'd0);
        rst_n = 1'b1;

        // Decided at digit 0, then held while idle.
        run8("a5_35", 8'hA5, 8'h35, 3'b100, 1);
        repeat (3) @(posedge clk);
        #1;
        check("a5_35_hold", 32'({done8, f1_8, f2_8, f3_8}), 32'b0100);

        run8("3c_3d", 8'h3C, 8'h3D, 3'b001, 4);
        run8("5a_5a", 8'h5A, 8'h5A, 3'b010, 4);

        for (int i = 0; i < 16; i++) begin
            run2(2'(i >> 2), 2'(i));
        end

        // A second start while busy must be ignored.
        @(negedge clk);
        a8 = 8'h10;
        b8 = 8'h10;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        lat = 0;
        pulses = 0;
        for (int c = 1; c <= 8; c++) begin
            if (c == 2) begin
                a8 = 8'hFF;
                b8 = 8'h00;
                start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            @(posedge clk);
            #1;
            if (done8) begin
                pulses++;
                if (lat == 0) lat = c;
            end
        end
        start8 = 1'b0;
        check("busy_start_pulses", 32'(pulses), 32'd1);
        check("busy_start_lat", 32'(lat), 32'd4);
        check("busy_start_flags", 32'({f1_8, f2_8, f3_8}), 32'b010);

        // Reset in the middle of a comparison.
        @(negedge clk);
        a8 = 8'h3C;
        b8 = 8'h3D;
        start8 = 1'b1;
        @(posedge clk);
        #1;
        start8 = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("midrun_reset", 32'({busy8, done8, f1_8, f2_8, f3_8}), 32'd0);
        pulses = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (done8) pulses++;
        end
        check("midrun_no_done", 32'(pulses), 32'd0);
        run8("01_02", 8'h01, 8'h02, 3'b001, 4);

`ifdef SIGNED_COMPARE_EN
        sm = 1'b1;
        run8("signed_80_01", 8'h80, 8'h01, 3'b001, 1);
        sm = 1'b0;
        run8("unsigned_80_01", 8'h80, 8'h01, 3'b100, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
